execute_hazard_ctrl: RTL and testbench
======================================

// Module: execute_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the execute stage. Generates PC/F-D/D-X stall and flush controls from:
//   - branch/jump redirects resolved in execute,
//   - load-use hazards between D-X and F-D,
//   - multi-cycle mult/div operations.
//  Owns the mult/div start/wait handshake, with a timeout, and keeps saturating performance counters.
// PARAMETERS
//  MD_TIMEOUT  64  max cycles to wait for md_ready before aborting with md_error
//  CNT_W       16  width of the performance counters
// PORTS
//  clock          in   1      pipeline clock, rising edge
//  reset_n        in   1      asynchronous, active-low reset
//  dx_valid       in   1      D-X latch holds a real instruction (not a bubble)
//  dx_opcode      in   5      opcode in D-X
//  dx_ALU_op      in   5      ALU_op field in D-X
//  dx_rd          in   5      destination register in D-X
//  fd_rs          in   5      rs source register in F-D
//  fd_rt          in   5      rt source register in F-D
//  take_branch    in   1      taken bne/blt/bex from execute
//  is_jump        in   1      j/jal/jr decoded in D-X
//  md_ready       in   1      mult/div unit result valid (1-cycle pulse)
//  md_start       out  1      1-cycle pulse: mult/div unit latches its operands
//  stall_pc       out  1      hold the PC register
//  stall_fd       out  1      hold the F-D latch
//  stall_dx       out  1      hold the D-X latch
//  flush_fd       out  1      load a nop into F-D
//  flush_dx       out  1      load a nop (bubble) into D-X
//  md_wb          out  1      1 cycle: write the mult/div result from X-M
//  md_error       out  1      sticky: mult/div timed out
//  stall_cycles   out  CNT_W  saturating count of cycles with stall_pc=1
//  flush_count    out  CNT_W  saturating count of redirect flushes
// BEHAVIOUR
//  Reset (reset_n=0, asynchronous):
//   - state=RUN, cnt=0, md_error=0, both counters=0.
//   - All control outputs are 0 while reset is held.
//  Decodes:
//   - md_op = dx_valid & opcode==00000 & ALU_op in {00110 mul, 00111 div}.
//   - lw = opcode 01000.
//   - redirect = dx_valid & (take_branch | is_jump).
//   - load_use = dx_valid & lw & dx_rd!=0 & (dx_rd==fd_rs | dx_rd==fd_rt).
//  FSM states: RUN, MD_WAIT, MD_DONE. Control outputs are combinational from state + inputs.
//  RUN:
//   - redirect: flush_fd=1, flush_dx=1, no stalls; flush_count++.
//     Redirect has priority over load_use and md_op.
//   - else md_op: md_start=1, stall_pc=stall_fd=1; next state MD_WAIT, cnt<=0.
//   - else load_use: stall_pc=stall_fd=1, flush_dx=1 for exactly 1 cycle.
//     The next cycle re-evaluates with the bubble in D-X, so load_use drops.
//  MD_WAIT:
//   - stall_pc=stall_fd=stall_dx=1 every cycle; redirect and load_use are ignored.
//   - md_ready=1: next MD_DONE.
//   - else cnt==MD_TIMEOUT-1: md_error<=1, next RUN.
//   - else cnt<=cnt+1.
//  MD_DONE:
//   - md_wb=1, flush_dx=1 (the D-X copy of the op is retired); next RUN.
//  Simultaneous events:
//   - md_ready arriving in the same cycle as md_start is ignored; the unit latency is >= 1.
//  Counters:
//   - stall_cycles increments on every cycle with stall_pc=1.
//   - Both counters saturate at all-ones and never wrap.
//  Reset asserted mid-MD_WAIT: returns to RUN immediately; md_start is not reissued.
//  md_error clears only on reset.
// TESTING
//  1. Taken bne in RUN -> flush_fd=flush_dx=1 for 1 cycle, no stall, flush_count 0->1.
//  2. lw $5 in D-X, fd_rs=5 -> stall_pc=stall_fd=flush_dx=1 for exactly 1 cycle.
//     With dx_rd=0 -> no stall.
//  3. mul in D-X, md_ready 17 cycles after md_start:
//     - md_start 1 cycle; stalls held for 18 cycles;
//     - md_wb=1 plus a 1-cycle flush_dx in MD_DONE;
//     - stall_cycles=18.
//  4. div with md_ready never asserted, MD_TIMEOUT=64:
//     - md_error=1 after 64 MD_WAIT cycles; FSM back in RUN; md_error stays set.
//  5. Redirect + load_use + md_op in the same RUN cycle -> only flush_fd/flush_dx; md_start=0.
//  6. Counter saturation (CNT_W=4): 20 stall cycles -> stall_cycles=15.
//     Reset pulsed during MD_WAIT -> all outputs 0, state RUN.

Source files
------------

// File: rtl/execute_hazard_ctrl.sv
// Execute-stage pipeline sequencer. It produces the PC, F-D and D-X stall and
// flush controls for three cases: branch/jump redirects, load-use hazards and
// multi-cycle mult/div operations. It also runs the mult/div start/wait
// handshake, with a timeout, and keeps saturating performance counters.
module execute_hazard_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             dx_valid,
  input  logic [4:0]       dx_opcode,
  input  logic [4:0]       dx_ALU_op,
  input  logic [4:0]       dx_rd,
  input  logic [4:0]       fd_rs,
  input  logic [4:0]       fd_rt,
  input  logic             take_branch,
  input  logic             is_jump,
  input  logic             md_ready,
  output logic             md_start,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             stall_dx,
  output logic             flush_fd,
  output logic             flush_dx,
  output logic             md_wb,
  output logic             md_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

  typedef enum logic [1:0] {RUN, MD_WAIT, MD_DONE} state_t;

  state_t        state;
  logic [TW-1:0] cnt;

  logic md_op;
  logic is_lw;
  logic redirect;
  logic load_use;

  // Decode the hazard sources from the D-X and F-D latch contents
  always_comb begin
    md_op    = dx_valid && (dx_opcode == 5'b00000) &&
               ((dx_ALU_op == 5'b00110) || (dx_ALU_op == 5'b00111));
    is_lw    = (dx_opcode == 5'b01000);
    redirect = dx_valid && (take_branch || is_jump);
    load_use = dx_valid && is_lw && (dx_rd != 5'd0) &&
               ((dx_rd == fd_rs) || (dx_rd == fd_rt));
  end

  // Pipeline controls come from state and inputs; all are forced low while
  // reset is held
  always_comb begin
    md_start = 1'b0;
    stall_pc = 1'b0;
    stall_fd = 1'b0;
    stall_dx = 1'b0;
    flush_fd = 1'b0;
    flush_dx = 1'b0;
    md_wb    = 1'b0;
    if (reset_n) begin
      unique case (state)
        RUN: begin
          if (redirect) begin
            flush_fd = 1'b1;
            flush_dx = 1'b1;
          end else if (md_op) begin
            md_start = 1'b1;
            stall_pc = 1'b1;
            stall_fd = 1'b1;
          end else if (load_use) begin
            stall_pc = 1'b1;
            stall_fd = 1'b1;
            flush_dx = 1'b1;
          end
        end
        MD_WAIT: begin
          stall_pc = 1'b1;
          stall_fd = 1'b1;
          stall_dx = 1'b1;
        end
        MD_DONE: begin
          md_wb    = 1'b1;
          flush_dx = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Mult/div handshake sequencing, wait timeout and the sticky error flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      cnt      <= '0;
      md_error <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (!redirect && md_op) begin
            state <= MD_WAIT;
            cnt   <= '0;
          end
        end
        MD_WAIT: begin
          if (md_ready) begin
            state <= MD_DONE;
          end else if (cnt == TW'(MD_TIMEOUT - 1)) begin
            md_error <= 1'b1;
            state    <= RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MD_DONE: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Saturating performance counters; flush_fd is raised only by a redirect
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_pc && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (flush_fd && (flush_count != '1))  flush_count  <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_execute_hazard_ctrl.sv
// Directed-sequence bench for execute_hazard_ctrl. The expected control vector
// for each cycle goes into a queue as that cycle's stimulus is driven. It comes
// out of the queue at the falling edge and is compared against two instances:
// one with default widths and one with 4-bit counters.
module tb_execute_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       dx_valid = 1'b0;
  logic [4:0] dx_opcode = '0;
  logic [4:0] dx_ALU_op = '0;
  logic [4:0] dx_rd = '0;
  logic [4:0] fd_rs = '0;
  logic [4:0] fd_rt = '0;
  logic       take_branch = 1'b0;
  logic       is_jump = 1'b0;
  logic       md_ready = 1'b0;

  logic        m_md_start, m_stall_pc, m_stall_fd, m_stall_dx;
  logic        m_flush_fd, m_flush_dx, m_md_wb, m_md_error;
  logic [15:0] m_stall_cycles, m_flush_count;
  logic        s_md_start, s_stall_pc, s_stall_fd, s_stall_dx;
  logic        s_flush_fd, s_flush_dx, s_md_wb, s_md_error;
  logic [3:0]  s_stall_cycles, s_flush_count;

  always #5 clock = ~clock;

  execute_hazard_ctrl #(.MD_TIMEOUT(64), .CNT_W(16)) u_dut (
    .clock(clock), .reset_n(reset_n), .dx_valid(dx_valid), .dx_opcode(dx_opcode),
    .dx_ALU_op(dx_ALU_op), .dx_rd(dx_rd), .fd_rs(fd_rs), .fd_rt(fd_rt),
    .take_branch(take_branch), .is_jump(is_jump), .md_ready(md_ready),
    .md_start(m_md_start), .stall_pc(m_stall_pc), .stall_fd(m_stall_fd),
    .stall_dx(m_stall_dx), .flush_fd(m_flush_fd), .flush_dx(m_flush_dx),
    .md_wb(m_md_wb), .md_error(m_md_error), .stall_cycles(m_stall_cycles),
    .flush_count(m_flush_count)
  );

  execute_hazard_ctrl #(.MD_TIMEOUT(64), .CNT_W(4)) u_sat (
    .clock(clock), .reset_n(reset_n), .dx_valid(dx_valid), .dx_opcode(dx_opcode),
    .dx_ALU_op(dx_ALU_op), .dx_rd(dx_rd), .fd_rs(fd_rs), .fd_rt(fd_rt),
    .take_branch(take_branch), .is_jump(is_jump), .md_ready(md_ready),
    .md_start(s_md_start), .stall_pc(s_stall_pc), .stall_fd(s_stall_fd),
    .stall_dx(s_stall_dx), .flush_fd(s_flush_fd), .flush_dx(s_flush_dx),
    .md_wb(s_md_wb), .md_error(s_md_error), .stall_cycles(s_stall_cycles),
    .flush_count(s_flush_count)
  );

  // {md_start, stall_pc, stall_fd, stall_dx, flush_fd, flush_dx, md_wb, md_error}
  typedef logic [7:0] ctl_t;
  localparam ctl_t IDLE  = 8'b0000_0000;
  localparam ctl_t REDIR = 8'b0000_1100;
  localparam ctl_t LU    = 8'b0110_0100;
  localparam ctl_t MDS   = 8'b1110_0000;
  localparam ctl_t WAITV = 8'b0111_0000;
  localparam ctl_t DONE  = 8'b0000_0110;

  ctl_t        exp_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;
  logic        exp_err = 1'b0;

  function automatic ctl_t main_ctl();
    return {m_md_start, m_stall_pc, m_stall_fd, m_stall_dx,
            m_flush_fd, m_flush_dx, m_md_wb, m_md_error};
  endfunction

  function automatic ctl_t sat_ctl();
    return {s_md_start, s_stall_pc, s_stall_fd, s_stall_dx,
            s_flush_fd, s_flush_dx, s_md_wb, s_md_error};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One pipeline cycle: the caller has just driven the inputs (posedge+1).
  // The expected controls are queued, checked at the falling edge, and folded
  // into the counter model before the next rising edge.
  task automatic cycle(input ctl_t e, input string tag);
    ctl_t x;
    exp_q.push_back(e | {7'b0, exp_err});
    @(negedge clock);
    x = exp_q.pop_front();
    check({tag, "/main"}, 32'(main_ctl()), 32'(x));
    check({tag, "/sat"},  32'(sat_ctl()),  32'(x));
    if (x[6]) exp_stall++;
    if (x[3]) exp_flush++;
    @(posedge clock);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "/stall_cycles"},     32'(m_stall_cycles), exp_stall);
    check({tag, "/flush_count"},      32'(m_flush_count),  exp_flush);
    check({tag, "/sat_stall_cycles"}, 32'(s_stall_cycles), (exp_stall > 15) ? 32'd15 : exp_stall);
    check({tag, "/sat_flush_count"},  32'(s_flush_count),  (exp_flush > 15) ? 32'd15 : exp_flush);
  endtask

  task automatic clear_inputs();
    dx_valid = 1'b0; dx_opcode = '0; dx_ALU_op = '0; dx_rd = '0;
    fd_rs = '0; fd_rt = '0; take_branch = 1'b0; is_jump = 1'b0; md_ready = 1'b0;
  endtask

  // Assert reset while driving inputs that would redirect in RUN. The outputs
  // must drop at once without waiting for a clock edge.
  task automatic do_reset(input string tag);
    dx_valid = 1'b1; take_branch = 1'b1; dx_opcode = 5'b00000; dx_ALU_op = 5'b00110;
    reset_n = 1'b0;
    #1;
    exp_stall = 0; exp_flush = 0; exp_err = 1'b0;
    check({tag, "/ctl_main"}, 32'(main_ctl()), 32'(IDLE));
    check({tag, "/ctl_sat"},  32'(sat_ctl()),  32'(IDLE));
    check_counters(tag);
    @(negedge clock);
    @(posedge clock);
    #1;
    clear_inputs();
    reset_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    @(posedge clock);
    #1;
    do_reset("reset0");
    cycle(IDLE, "idle0");

    // Taken bne in RUN
    dx_valid = 1'b1; dx_opcode = 5'b00010; take_branch = 1'b1;
    cycle(REDIR, "bne");
    clear_inputs();
    cycle(IDLE, "after_bne");
    check_counters("bne");

    // Load-use on rs, then the bubble in D-X
    dx_valid = 1'b1; dx_opcode = 5'b01000; dx_rd = 5'd5; fd_rs = 5'd5;
    cycle(LU, "lu_rs");
    dx_valid = 1'b0;
    cycle(IDLE, "lu_rs_bubble");
    // Load-use on rt
    dx_valid = 1'b1; dx_rd = 5'd7; fd_rs = 5'd3; fd_rt = 5'd7;
    cycle(LU, "lu_rt");
    dx_valid = 1'b0;
    cycle(IDLE, "lu_rt_bubble");
    // lw to $0 and lw without a matching source never stall
    dx_valid = 1'b1; dx_rd = 5'd0; fd_rs = 5'd0; fd_rt = 5'd0;
    cycle(IDLE, "lu_r0");
    dx_rd = 5'd9; fd_rs = 5'd8; fd_rt = 5'd10;
    cycle(IDLE, "lw_nomatch");
    clear_inputs();
    check_counters("lu");

    // mul, md_ready 17 cycles after md_start (the same-cycle md_ready is ignored)
    do_reset("reset_mul");
    dx_valid = 1'b1; dx_opcode = 5'b00000; dx_ALU_op = 5'b00110; md_ready = 1'b1;
    cycle(MDS, "mul_start");
    md_ready = 1'b0;
    for (int unsigned i = 1; i <= 16; i++) begin
      take_branch = (i == 4);
      cycle(WAITV, $sformatf("mul_wait%0d", i));
    end
    take_branch = 1'b0; md_ready = 1'b1;
    cycle(WAITV, "mul_wait17");
    clear_inputs();
    cycle(DONE, "mul_done");
    cycle(IDLE, "mul_after");
    check_counters("mul");

    // div that never completes: times out after 64 wait cycles
    dx_valid = 1'b1; dx_opcode = 5'b00000; dx_ALU_op = 5'b00111;
    cycle(MDS, "div_start");
    for (int unsigned i = 1; i <= 64; i++) cycle(WAITV, $sformatf("div_wait%0d", i));
    exp_err = 1'b1;
    clear_inputs();
    cycle(IDLE, "div_timeout");
    cycle(IDLE, "div_err_sticky");
    check_counters("div");

    // Redirect wins over md_op and over load_use
    dx_valid = 1'b1; dx_opcode = 5'b00000; dx_ALU_op = 5'b00110; take_branch = 1'b1;
    cycle(REDIR, "redir_md");
    take_branch = 1'b0; is_jump = 1'b1;
    dx_opcode = 5'b01000; dx_rd = 5'd4; fd_rt = 5'd4;
    cycle(REDIR, "jump_lu");
    clear_inputs();
    cycle(IDLE, "after_prio");
    check_counters("prio");

    // 20 stall cycles: the 4-bit counter saturates at 15
    do_reset("reset_sat");
    dx_valid = 1'b1; dx_opcode = 5'b00000; dx_ALU_op = 5'b00110;
    cycle(MDS, "sat_start");
    for (int unsigned i = 1; i <= 18; i++) cycle(WAITV, $sformatf("sat_wait%0d", i));
    md_ready = 1'b1;
    cycle(WAITV, "sat_wait19");
    clear_inputs();
    cycle(DONE, "sat_done");
    check_counters("sat");

    // Reset in the middle of MD_WAIT returns to RUN without a new md_start
    dx_valid = 1'b1; dx_opcode = 5'b00000; dx_ALU_op = 5'b00111;
    cycle(MDS, "mid_start");
    for (int unsigned i = 1; i <= 3; i++) cycle(WAITV, $sformatf("mid_wait%0d", i));
    do_reset("reset_mid");
    cycle(IDLE, "mid_run_idle");
    dx_valid = 1'b1; is_jump = 1'b1;
    cycle(REDIR, "mid_run_redir");
    clear_inputs();
    cycle(IDLE, "mid_end");
    check_counters("mid");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
